dmem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer in front of the single-ported, byte-addressed data memory.
- Requester 0 is the CPU load/store path; requester 1 is the debug/DMA loader.
- Accepts one request at a time, drives the memory port for exactly one access cycle, then returns a registered response (read data or write ack) to the winner.
- Round-robin fairness on simultaneous requests.

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and one-cycle access sequencer for the data memory.
// Optional macro DMEM_ARB_RANGE_CHECK_EN adds r0_err/r1_err and suppresses out-of-range accesses.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WIDTH  = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic [3:0]            r0_be,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  input  logic [3:0]            r1_be,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [MEM_WIDTH-1:0]  mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  input  logic [DATA_WIDTH-1:0] mem_rd
`ifdef DMEM_ARB_RANGE_CHECK_EN
  ,
  output logic                  r0_err,
  output logic                  r1_err
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state, state_next;

  logic                  last_grant;
  logic                  grant;
  logic                  pick;
  logic                  lat_id;
  logic                  lat_we;
  logic                  lat_err;
  logic [MEM_WIDTH-1:0]  lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [3:0]            lat_be;

  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [3:0]            sel_be;
  logic                  sel_err;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    pick       = 1'b0;
    r0_gnt     = 1'b0;
    r1_gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (r0_req || r1_req) begin
          grant      = 1'b1;
          pick       = (r0_req && r1_req) ? ~last_grant : r1_req;
          r0_gnt     = ~pick;
          r1_gnt     = pick;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign sel_we    = pick ? r1_we    : r0_we;
  assign sel_addr  = pick ? r1_addr  : r0_addr;
  assign sel_wdata = pick ? r1_wdata : r0_wdata;
  assign sel_be    = pick ? r1_be    : r0_be;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  assign sel_err = |sel_addr[ADDR_WIDTH-1:MEM_WIDTH];
`else
  logic unused_upper;
  assign sel_err      = 1'b0;
  assign unused_upper = |sel_addr[ADDR_WIDTH-1:MEM_WIDTH];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lat_id     <= 1'b0;
      lat_we     <= 1'b0;
      lat_err    <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_be     <= '0;
    end else begin
      state <= state_next;
      if (grant) begin
        last_grant <= pick;
        lat_id     <= pick;
        lat_we     <= sel_we;
        lat_err    <= sel_err;
        lat_addr   <= sel_addr[MEM_WIDTH-1:0];
        lat_wdata  <= sel_wdata;
        lat_be     <= sel_be;
      end
    end
  end

  // Strobes decode from state so an asynchronous reset kills a pending write at once.
  assign mem_a  = lat_addr;
  assign mem_wd = lat_wdata;
  assign mem_we = (state == ACCESS) && lat_we && !lat_err;
  assign mem_be = (state == ACCESS) ? lat_be : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      if (state == ACCESS) begin
        if (!lat_id) begin
          r0_rvalid <= 1'b1;
          if (!lat_we) r0_rdata <= lat_err ? '0 : mem_rd;
        end else begin
          r1_rvalid <= 1'b1;
          if (!lat_we) r1_rdata <= lat_err ? '0 : mem_rd;
        end
      end
    end
  end

`ifdef DMEM_ARB_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_err <= 1'b0;
      r1_err <= 1'b0;
    end else begin
      r0_err <= (state == ACCESS) && lat_err && !lat_id;
      r1_err <= (state == ACCESS) && lat_err && lat_id;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte-addressed memory model.
// Covers DMEM_ARB_RANGE_CHECK_EN builds through matching ifdefs.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        r0_req, r0_we, r1_req, r1_we;
  logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;
  logic [3:0]  r0_be, r1_be;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [31:0] r0_rdata, r1_rdata;
  logic [11:0] mem_a;
  logic [31:0] mem_wd, mem_rd;
  logic        mem_we;
  logic [3:0]  mem_be;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  logic        r0_err, r1_err;
`endif

  logic [7:0]  mem [0:4095];
  int          errors;
  int          checks;
  int          w;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata), .r0_be(r0_be),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata), .r1_be(r1_be),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_be(mem_be), .mem_rd(mem_rd)
`ifdef DMEM_ARB_RANGE_CHECK_EN
    , .r0_err(r0_err), .r1_err(r1_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Little-endian byte memory; reads are combinational and wrap within 4 KiB.
  assign mem_rd = {mem[mem_a + 12'd3], mem[mem_a + 12'd2], mem[mem_a + 12'd1], mem[mem_a]};

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_be[0]) mem[mem_a]         <= mem_wd[7:0];
      if (mem_be[1]) mem[mem_a + 12'd1] <= mem_wd[15:8];
      if (mem_be[2]) mem[mem_a + 12'd2] <= mem_wd[23:16];
      if (mem_be[3]) mem[mem_a + 12'd3] <= mem_wd[31:24];
    end
  end

  task automatic applyStimulus(input logic id, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be);
    if (!id) begin
      r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata; r0_be = be;
    end else begin
      r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata; r1_be = be;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h010] = 8'h11; mem[12'h011] = 8'h22; mem[12'h012] = 8'h33; mem[12'h013] = 8'h44;
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Reset state
    #2;
    checkOutput("rst_r0_gnt", r0_gnt, 0);
    checkOutput("rst_r1_gnt", r1_gnt, 0);
    checkOutput("rst_r0_rvalid", r0_rvalid, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_be", mem_be, 0);
    checkOutput("rst_mem_a", mem_a, 0);
    checkOutput("rst_mem_wd", mem_wd, 0);
    checkOutput("rst_r0_rdata", r0_rdata, 0);
    tick;
    rst = 1'b0;

    // Single read from r0
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h010, 32'h0, 4'hF);
    #1;
    checkOutput("rd_r0_gnt", r0_gnt, 1);
    checkOutput("rd_r1_gnt", r1_gnt, 0);
    tick;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h010, 32'h0, 4'hF);
    #1;
    checkOutput("rd_mem_a", mem_a, 32'h010);
    checkOutput("rd_mem_we", mem_we, 0);
    checkOutput("rd_mem_be", mem_be, 32'hF);
    checkOutput("rd_gnt_in_access", r0_gnt, 0);
    tick;
    checkOutput("rd_r0_rvalid", r0_rvalid, 1);
    checkOutput("rd_r0_rdata", r0_rdata, 32'h44332211);
    checkOutput("rd_r1_rvalid", r1_rvalid, 0);
    checkOutput("rd_idle_mem_be", mem_be, 0);
    tick;
    checkOutput("rd_rvalid_pulse", r0_rvalid, 0);

    // r1 partial write then read back
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h020, 32'hDEADBEEF, 4'b0011);
    #1;
    checkOutput("wr_r1_gnt", r1_gnt, 1);
    checkOutput("wr_r0_gnt", r0_gnt, 0);
    tick;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h020, 32'h0, 4'hF);
    #1;
    checkOutput("wr_mem_we", mem_we, 1);
    checkOutput("wr_mem_be", mem_be, 32'h3);
    checkOutput("wr_mem_a", mem_a, 32'h020);
    checkOutput("wr_mem_wd", mem_wd, 32'hDEADBEEF);
    tick;
    checkOutput("wr_mem_we_drop", mem_we, 0);
    checkOutput("wr_r1_rvalid", r1_rvalid, 1);
    checkOutput("wr_r1_rdata_kept", r1_rdata, 0);
    checkOutput("wr_mem_byte20", {24'h0, mem[12'h020]}, 32'hEF);
    checkOutput("wr_mem_byte22", {24'h0, mem[12'h022]}, 32'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h020, 32'h0, 4'hF);
    #1;
    checkOutput("rb_r1_gnt", r1_gnt, 1);
    tick;
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h020, 32'h0, 4'hF);
    tick;
    checkOutput("rb_r1_rvalid", r1_rvalid, 1);
    checkOutput("rb_r1_rdata", r1_rdata, 32'h0000BEEF);

    // Contention: r1 was granted last, so r0 leads and grants alternate
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h010, 32'h0, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h020, 32'h0, 4'hF);
    #1;
    for (int k = 0; k < 6; k++) begin
      w = k % 2;
      checkOutput("cont_r0_gnt", r0_gnt, (w == 0));
      checkOutput("cont_r1_gnt", r1_gnt, (w == 1));
      if (k > 0) begin
        checkOutput("cont_r0_rvalid", r0_rvalid, (w == 1));
        checkOutput("cont_r1_rvalid", r1_rvalid, (w == 0));
      end
      tick;
      if (k == 5) begin
        r0_req = 1'b0;
        r1_req = 1'b0;
      end
      #1;
      checkOutput("cont_no_gnt0", r0_gnt, 0);
      checkOutput("cont_no_gnt1", r1_gnt, 0);
      tick;
    end
    checkOutput("cont_last_r1_rvalid", r1_rvalid, 1);
    checkOutput("cont_last_r0_rvalid", r0_rvalid, 0);
    checkOutput("cont_r0_rdata", r0_rdata, 32'h44332211);
    checkOutput("cont_r1_rdata", r1_rdata, 32'h0000BEEF);
    tick;

    // Reset during a write ACCESS
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h030, 32'h00000055, 4'b0001);
    #1;
    checkOutput("rsta_r0_gnt", r0_gnt, 1);
    tick;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h030, 32'h0, 4'h0);
    #1;
    checkOutput("rsta_mem_we_pre", mem_we, 1);
    rst = 1'b1;
    #1;
    checkOutput("rsta_mem_we_now", mem_we, 0);
    checkOutput("rsta_mem_be_now", mem_be, 0);
    tick;
    checkOutput("rsta_mem30", {24'h0, mem[12'h030]}, 0);
    checkOutput("rsta_r0_rvalid", r0_rvalid, 0);
    checkOutput("rsta_r0_rdata", r0_rdata, 0);
    rst = 1'b0;

    // Tie after reset: r0 wins again even though it was granted last
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h010, 32'h0, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h020, 32'h0, 4'hF);
    #1;
    checkOutput("tie_r0_gnt", r0_gnt, 1);
    checkOutput("tie_r1_gnt", r1_gnt, 0);
    tick;
    r0_req = 1'b0;
    tick;
    checkOutput("tie_r0_rvalid", r0_rvalid, 1);
    checkOutput("tie_r1_gnt_next", r1_gnt, 1);
    tick;
    r1_req = 1'b0;
    tick;
    checkOutput("tie_r1_rvalid", r1_rvalid, 1);
    checkOutput("tie_r1_rdata", r1_rdata, 32'h0000BEEF);

    // r1 request pulsed only while in ACCESS is never served
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h010, 32'h0, 4'hF);
    #1;
    checkOutput("wd_r0_gnt", r0_gnt, 1);
    tick;
    r0_req = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h020, 32'h0, 4'hF);
    #1;
    checkOutput("wd_r1_gnt_access", r1_gnt, 0);
    tick;
    r1_req = 1'b0;
    #1;
    checkOutput("wd_r1_gnt_idle", r1_gnt, 0);
    checkOutput("wd_r0_rvalid", r0_rvalid, 1);
    tick;
    checkOutput("wd_r1_rvalid", r1_rvalid, 0);
    checkOutput("wd_mem_be_idle", mem_be, 0);
    checkOutput("wd_mem_a_hold", mem_a, 32'h010);

    // Out-of-range write to 0x1004
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h00001004, 32'hA5A5A5A5, 4'hF);
    #1;
    checkOutput("rng_r0_gnt", r0_gnt, 1);
    tick;
    r0_req = 1'b0;
    #1;
    checkOutput("rng_mem_a", mem_a, 32'h004);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    checkOutput("rng_mem_we", mem_we, 0);
`else
    checkOutput("rng_mem_we", mem_we, 1);
`endif
    tick;
    checkOutput("rng_r0_rvalid", r0_rvalid, 1);
`ifdef DMEM_ARB_RANGE_CHECK_EN
    checkOutput("rng_r0_err", r0_err, 1);
    checkOutput("rng_r1_err", r1_err, 0);
    checkOutput("rng_mem4", {24'h0, mem[12'h004]}, 32'h00);
`else
    checkOutput("rng_mem4", {24'h0, mem[12'h004]}, 32'hA5);
    checkOutput("rng_mem7", {24'h0, mem[12'h007]}, 32'hA5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
